// File: rtl/demux_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demux_channel_sequencer
// Brief    : Break-before-make channel sequencer for a 1-to-4 demux stage.
//            Walks a latched channel mask in ascending order with a fixed
//            dwell per channel and a one-cycle gap between channels.
// Revision : 1.0 - initial release
// ============================================================================
module demux_channel_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_nxt;
    logic               r_enable;
    logic               w_enable_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [3:0]         r_mask;
    logic [3:0]         w_mask_nxt;
    logic               r_cont;
    logic               w_cont_nxt;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic [1:0]         w_first_req;
    logic [1:0]         w_first_lat;
    logic [1:0]         w_next_ch;
    logic               w_next_found;
    logic               w_expired;

    localparam logic [DWELL_W-1:0] C_ONE = DWELL_W'(1);

    assign w_dwell_eff = (dwell == '0) ? C_ONE : dwell;
    assign w_expired   = (r_cnt <= C_ONE);

    // Lowest set bit of the requested and latched masks; downward scan leaves the lowest.
    always_comb begin
        w_first_req = 2'd0;
        w_first_lat = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                w_first_req = 2'(i);
            end
            if (r_mask[i]) begin
                w_first_lat = 2'(i);
            end
        end
    end

    // Next set bit of the latched mask strictly above the current channel.
    always_comb begin
        w_next_found = 1'b0;
        w_next_ch    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_found = 1'b1;
                w_next_ch    = 2'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_enable_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_dwell_nxt  = r_dwell;
        w_mask_nxt   = r_mask;
        w_cont_nxt   = r_cont;

        case (r_state)
            S_IDLE: begin
                if (start && !stop && (mask != 4'd0)) begin
                    w_mask_nxt   = mask;
                    w_cont_nxt   = continuous;
                    w_dwell_nxt  = w_dwell_eff;
                    w_cnt_nxt    = w_dwell_eff;
                    w_sel_nxt    = w_first_req;
                    w_enable_nxt = 1'b1;
                    w_state_nxt  = S_ON;
                end
            end

            S_ON: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expired) begin
                    if (w_next_found) begin
                        w_sel_nxt   = w_next_ch;
                        w_state_nxt = S_GAP;
                    end else if (r_cont) begin
                        w_sel_nxt   = w_first_lat;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_enable_nxt = 1'b1;
                    w_cnt_nxt    = r_cnt - C_ONE;
                end
            end

            S_GAP: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt    = r_dwell;
                    w_enable_nxt = 1'b1;
                    w_state_nxt  = S_ON;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'd0;
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_mask   <= 4'd0;
            r_cont   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_enable <= w_enable_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dwell  <= w_dwell_nxt;
            r_mask   <= w_mask_nxt;
            r_cont   <= w_cont_nxt;
        end
    end

    assign sel    = r_sel;
    assign enable = r_enable;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demux_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_channel_sequencer
// Brief    : Schedule-based reference model, directed scenarios and random
//            stimulus for demux_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_channel_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [7:0] dwell = 8'd0;
    logic [1:0] sel;
    logic       enable;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    demux_channel_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .enable     (enable),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: each entry is the expected {sel, enable, busy, done} of one future cycle.
    logic [4:0] q[$];
    logic [4:0] exp_v = 5'd0;
    logic [3:0] m_mask = 4'd0;
    int         m_d = 1;
    bit         m_cont = 1'b0;

    function automatic void push_rot(input logic [3:0] mk, input int d, input bit cont);
        int ch[$];
        for (int i = 0; i < 4; i++) if (mk[i]) ch.push_back(i);
        for (int k = 0; k < ch.size(); k++) begin
            for (int c = 0; c < d; c++) q.push_back({2'(ch[k]), 3'b110});
            if (k < ch.size() - 1) q.push_back({2'(ch[k + 1]), 3'b010});
        end
        if (cont) q.push_back({2'(ch[0]), 3'b010});
        else      q.push_back({2'(ch[ch.size() - 1]), 3'b001});
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [4:0] prev;
        if (reset) begin
            q.delete();
            exp_v  = 5'd0;
            m_cont = 1'b0;
        end else begin
            prev = exp_v;
            if (prev[1] && stop) begin
                q.delete();
                exp_v = {prev[4:3], 3'b000};
            end else if (!prev[1] && start && !stop && (mask != 4'd0)) begin
                q.delete();
                m_mask = mask;
                m_d    = (dwell == 8'd0) ? 1 : int'(dwell);
                m_cont = continuous;
                push_rot(m_mask, m_d, m_cont);
                exp_v = q.pop_front();
            end else if (q.size() != 0) begin
                exp_v = q.pop_front();
            end else begin
                exp_v = {prev[4:3], 3'b000};
            end
            if (q.size() == 0 && m_cont && exp_v[1]) push_rot(m_mask, m_d, 1'b1);
        end
    end

    // Per-cycle compare, break-before-make check, channel-order and done tracking.
    logic [1:0] prev_sel = 2'd0;
    logic       prev_en = 1'b0;
    int         order[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        chk("sel", 32'(sel), 32'(exp_v[4:3]));
        chk("enable", 32'(enable), 32'(exp_v[2]));
        chk("busy", 32'(busy), 32'(exp_v[1]));
        chk("done", 32'(done), 32'(exp_v[0]));
        chk("bbm_violation", 32'(prev_en && enable && (sel != prev_sel)), 32'd0);
        if (enable && !prev_en) order.push_back(int'(sel));
        if (done) done_cnt++;
        prev_en  = enable;
        prev_sel = sel;
    end

    function automatic logic [31:0] order_pack();
        logic [31:0] v = 32'd0;
        foreach (order[i]) v = (v << 4) | 32'(order[i]);
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [3:0] m, input logic [7:0] d, input bit c);
        mask = m;
        dwell = d;
        continuous = c;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            cyc(1);
        end
    endtask

    int n;

    initial begin
        #1 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_enable", 32'(enable), 32'd0);
        cyc(1);

        // Single sweep over all channels, dwell 3.
        order.delete(); done_cnt = 0;
        go(4'b1111, 8'd3, 1'b0);
        busy_len(n);
        chk("t1_busy_len", 32'(n), 32'd15);
        chk("t1_done_hi", 32'(done), 32'd1);
        cyc(1);
        chk("t1_done_lo", 32'(done), 32'd0);
        chk("t1_sel_hold", 32'(sel), 32'd3);
        chk("t1_order_n", 32'(order.size()), 32'd4);
        chk("t1_order", order_pack(), 32'h0123);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        cyc(2);

        // Sparse mask with dwell zero.
        order.delete();
        go(4'b1010, 8'd0, 1'b0);
        busy_len(n);
        chk("t2_busy_len", 32'(n), 32'd3);
        chk("t2_done_hi", 32'(done), 32'd1);
        chk("t2_order", order_pack(), 32'h13);
        cyc(2);

        // Continuous 0,3 rotation; stop on the first ON cycle of the 4th visit to ch3.
        order.delete(); done_cnt = 0;
        go(4'b1001, 8'd2, 1'b1);
        cyc(21);
        chk("t3_sel_before_stop", 32'(sel), 32'd3);
        chk("t3_en_before_stop", 32'(enable), 32'd1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t3_enable_off", 32'(enable), 32'd0);
        chk("t3_busy_off", 32'(busy), 32'd0);
        chk("t3_sel_frozen", 32'(sel), 32'd3);
        chk("t3_order_n", 32'(order.size()), 32'd8);
        chk("t3_order", order_pack(), 32'h03030303);
        cyc(3);
        chk("t3_no_done", 32'(done_cnt), 32'd0);

        // Ignored starts.
        go(4'b0000, 8'd5, 1'b0);
        chk("t4_empty_mask", 32'(busy), 32'd0);
        cyc(2);
        chk("t4_empty_mask_late", 32'(busy), 32'd0);
        order.delete();
        go(4'b0011, 8'd4, 1'b0);
        cyc(2);
        mask = 4'b1100; dwell = 8'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        busy_len(n);
        chk("t4_restart_len", 32'(n), 32'd6);
        chk("t4_restart_order", order_pack(), 32'h01);
        cyc(1);
        mask = 4'b1111; start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("t4_start_stop", 32'(busy), 32'd0);
        cyc(2);

        // Asynchronous reset while on channel 2.
        go(4'b0111, 8'd4, 1'b0);
        cyc(11);
        chk("t5_on_ch2", 32'(sel), 32'd2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_sel", 32'(sel), 32'd0);
        chk("t5_async_enable", 32'(enable), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_done", 32'(done), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        order.delete();
        go(4'b1111, 8'd3, 1'b0);
        busy_len(n);
        chk("t5_resume_len", 32'(n), 32'd15);
        chk("t5_resume_order", order_pack(), 32'h0123);
        cyc(2);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            mask       = 4'($urandom);
            dwell      = 8'($urandom_range(0, 4));
            continuous = 1'($urandom_range(0, 1));
            cyc(1);
        end
        start = 1'b0;
        stop  = 1'b1;
        cyc(2);
        stop  = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_channel_sequencer.md
# demux_channel_sequencer

Registered sequencer that drives the `sel` and `enable` inputs of the 1-to-4 output demultiplexer stage directly downstream. It visits a programmable subset of the four channels in ascending order, holding `enable` high for a programmable dwell time per channel. Between channels it inserts a one-cycle break-before-make gap, so the demux never sees `sel` change while `enable` is high. It supports single-sweep mode with a completion pulse and continuous mode, which runs until stopped.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `stop`  in  1  abort the sequence; sampled in every state.
- `continuous`  in  1  sampled with `start`: 1 = loop forever, 0 = single sweep.
- `mask`  in  4  channel-enable mask; bit i set = visit channel i. Latched at start.
- `dwell`  in  DWELL_W  number of cycles `enable` stays high per channel; 0 is treated as 1. Latched at start.
- `sel`  out  2  channel select to the demux; registered.
- `enable`  out  1  data/enable to the demux; registered.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse when a single sweep completes normally.

## Operation
- **State machine:** IDLE, ON, GAP. All outputs are registered.
- **IDLE**
  - `enable`=0, `busy`=0, `sel` holds its last value.
  - If `start`=1, `stop`=0 and `mask`≠0: latch `mask`, `continuous` and D=max(`dwell`,1). Load `sel` with the lowest set mask bit, load the dwell counter, and go to ON.
  - `start` with `mask`=0 is ignored: no `busy`, no `done`.
- **ON**
  - `enable`=1 for exactly D cycles; the counter decrements each cycle.
  - When the count expires, choose the next channel: the next set bit of the latched mask strictly above `sel`.
    - If one exists, go to GAP and update `sel` on entry.
    - If none exists and the mode is continuous, wrap to the lowest set bit, go to GAP and update `sel`.
    - If none exists and the mode is single, go to IDLE and assert `done` for one cycle; `sel` is unchanged.
- **GAP**
  - `enable`=0 for exactly one cycle; `sel` already shows the next channel.
  - Reload the counter and go to ON.
- **Single-channel mask in continuous mode:** the block cycles ON(D)/GAP(1) on the same channel; `sel` is rewritten with the same value.
- **stop**
  - In any non-IDLE state, `stop`=1 forces IDLE at the next edge: `enable`=0, `done`=0, `sel` frozen.
  - `start` and `stop` asserted together in IDLE: `stop` wins and the block stays in IDLE.
- **start while busy:** ignored. Changes to `mask`/`dwell` while busy have no effect.
- **reset:** asynchronously forces IDLE with `sel`=0, `enable`=0, `busy`=0, `done`=0, dwell counter 0 and latched mask 0. This applies mid-sequence as well, with no completion pulse.
- **Invariant:** `sel` changes only on an edge where `enable` goes from 1 to 0 or `enable` is 0. `enable` is never 1 on two different channels without an intervening `enable`=0 cycle.

## Timing
- `start` is sampled at edge k. From edge k+1: `busy`=1, `enable`=1, `sel`=first channel.
- Each channel occupies D cycles of `enable`=1. Consecutive channels are separated by exactly 1 GAP cycle.
- A single sweep over N channels keeps `busy` high for N·D + (N−1) cycles. In the following cycle `busy`=0 and `done`=1; `done` returns to 0 one cycle later.
- Continuous period per channel: D+1 cycles.
- Latency of `stop` asserted at edge m: `enable`=0 and `busy`=0 from edge m+1.
- A new `start` is accepted in the same cycle that `done` is high.

## Test plan
- **Single sweep, all channels.** Setup: `mask`=4'b1111, `dwell`=3, `continuous`=0, `start` pulse. Expected:
  - `sel` 0,1,2,3, each with `enable` high for 3 cycles and 1-cycle gaps;
  - `busy` high for 15 cycles;
  - one `done` pulse, then `sel` holds 3.
- **Sparse mask, dwell zero.** Setup: `mask`=4'b1010, `dwell`=0. Expected:
  - `sel`=1 with `enable` high 1 cycle, gap, then `sel`=3 with `enable` high 1 cycle;
  - `busy` high for 3 cycles, then `done`.
- **Continuous with stop.** Setup: `mask`=4'b1001, `dwell`=2, `continuous`=1; run 3 full rotations, then assert `stop` mid-ON on channel 3. Expected:
  - channel order 0,3,0,3,…;
  - `enable` and `busy` low the next cycle;
  - no `done` pulse.
- **Ignored starts.** Expected:
  - `start` with `mask`=0 leaves `busy` at 0;
  - re-asserting `start` mid-sweep with a different mask does not alter the sequence;
  - `start`+`stop` together in IDLE leaves the block in IDLE.
- **Reset mid-operation.** Stimulus: assert `reset` asynchronously between clock edges while in ON on channel 2. Expected:
  - `sel`=0 and `enable`=0 immediately, without waiting for a clock edge;
  - `busy`=0 and `done`=0;
  - normal sweep resumes on the next `start`.
- **Break-before-make check over all tests.** A bench checker flags any edge where `sel` changes while `enable` was 1 in the prior and current cycle. Expected: zero violations.
